// File: rtl/serial_chain_scheduler_if.sv
// Bus bundle between a host and the serial chain scheduler: per-chain
// request/ack handshakes, parallel data words and the shared serial pins.
interface serial_chain_scheduler_if #(
  parameter int unsigned WIDTH = 16
);
  logic             i_LEDReq;
  logic [WIDTH-1:0] i_LEDData16;
  logic             o_LEDAck;
  logic             i_SEGReq;
  logic [WIDTH-1:0] i_SEGData16;
  logic             o_SEGAck;
  logic             i_DIPReq;
  logic [WIDTH-1:0] o_DIP16;
  logic             o_DIPValid;
  logic             o_PSCLK;
  logic             o_LEDData;
  logic             o_LEDLatch;
  logic             o_SEGData;
  logic             o_SEGLatch;
  logic             o_DIPLatch;
  logic             i_DIPData;
  logic             o_Busy;

  modport master (
    output i_LEDReq, i_LEDData16, i_SEGReq, i_SEGData16, i_DIPReq, i_DIPData,
    input  o_LEDAck, o_SEGAck, o_DIP16, o_DIPValid, o_PSCLK, o_LEDData,
           o_LEDLatch, o_SEGData, o_SEGLatch, o_DIPLatch, o_Busy
  );

  modport slave (
    input  i_LEDReq, i_LEDData16, i_SEGReq, i_SEGData16, i_DIPReq, i_DIPData,
    output o_LEDAck, o_SEGAck, o_DIP16, o_DIPValid, o_PSCLK, o_LEDData,
           o_LEDLatch, o_SEGData, o_SEGLatch, o_DIPLatch, o_Busy
  );
endinterface

// File: rtl/serial_chain_scheduler.sv
// Round-robin scheduler sharing one serial shift clock between an LED chain,
// a 7-segment chain (both write) and a DIP-switch chain (read).
module serial_chain_scheduler #(
  parameter int unsigned HALF_PERIOD = 2,
  parameter int unsigned WIDTH       = 16
) (
  input logic                     i_CLK,
  input logic                     i_RESET,
  serial_chain_scheduler_if.slave io_bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_PRELATCH, S_SHIFT, S_LATCH, S_DONE
  } state_t;

  typedef enum logic [1:0] {
    CH_LED, CH_SEG, CH_DIP
  } chan_t;

  // Phase counter covers one full PSCLK period (up to 510 cycles at HALF_PERIOD=255).
  localparam logic [8:0] C_HALF       = 9'(HALF_PERIOD);
  localparam logic [8:0] C_PHASE_LAST = 9'(2 * HALF_PERIOD - 1);
  localparam logic [4:0] C_BIT_LAST   = 5'(WIDTH - 1);

  state_t           r_state;
  state_t           w_nextState;
  chan_t            r_grant;
  chan_t            r_last;
  chan_t            w_pick;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] r_dip16;
  logic [WIDTH-1:0] w_shiftIn;
  logic [4:0]       r_bitCnt;
  logic [8:0]       r_phaseCnt;
  logic             w_anyReq;
  logic             w_phaseLast;
  logic             w_bitLast;
  logic             w_sampleNow;

  assign w_anyReq    = io_bus.i_LEDReq | io_bus.i_SEGReq | io_bus.i_DIPReq;
  assign w_phaseLast = (r_phaseCnt == C_PHASE_LAST);
  assign w_bitLast   = (r_bitCnt == C_BIT_LAST);
  assign w_sampleNow = (r_phaseCnt == C_HALF);
  assign w_shiftIn   = {r_shift[WIDTH-2:0], io_bus.i_DIPData};

  // Search starts with the chain after the most recently granted one.
  always_comb begin
    w_pick = CH_LED;
    case (r_last)
      CH_LED: begin
        if (io_bus.i_SEGReq)      w_pick = CH_SEG;
        else if (io_bus.i_DIPReq) w_pick = CH_DIP;
        else                      w_pick = CH_LED;
      end
      CH_SEG: begin
        if (io_bus.i_DIPReq)      w_pick = CH_DIP;
        else if (io_bus.i_LEDReq) w_pick = CH_LED;
        else                      w_pick = CH_SEG;
      end
      default: begin
        if (io_bus.i_LEDReq)      w_pick = CH_LED;
        else if (io_bus.i_SEGReq) w_pick = CH_SEG;
        else                      w_pick = CH_DIP;
      end
    endcase
  end

  always_ff @(posedge i_CLK) begin
    if (i_RESET) begin
      r_state    <= S_IDLE;
      r_grant    <= CH_LED;
      r_last     <= CH_DIP;
      r_shift    <= '0;
      r_dip16    <= '0;
      r_bitCnt   <= '0;
      r_phaseCnt <= '0;
    end else begin
      r_state <= w_nextState;
      case (r_state)
        S_IDLE: begin
          if (w_anyReq) begin
            r_grant <= w_pick;
            r_last  <= w_pick;
          end
        end
        S_LOAD: begin
          r_shift    <= (r_grant == CH_LED) ? io_bus.i_LEDData16 :
                        (r_grant == CH_SEG) ? io_bus.i_SEGData16 : '0;
          r_bitCnt   <= '0;
          r_phaseCnt <= '0;
        end
        S_PRELATCH, S_LATCH: begin
          r_phaseCnt <= w_phaseLast ? 9'd0 : r_phaseCnt + 9'd1;
        end
        S_SHIFT: begin
          r_phaseCnt <= w_phaseLast ? 9'd0 : r_phaseCnt + 9'd1;
          if (w_phaseLast) r_bitCnt <= r_bitCnt + 5'd1;
          // DIP bits enter on the PSCLK rise; the last one may land on the final edge.
          if (r_grant == CH_DIP) begin
            if (w_sampleNow) r_shift <= w_shiftIn;
            if (w_phaseLast && w_bitLast) r_dip16 <= w_sampleNow ? w_shiftIn : r_shift;
          end else if (w_phaseLast) begin
            r_shift <= {r_shift[WIDTH-2:0], 1'b0};
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_nextState       = r_state;
    io_bus.o_PSCLK    = 1'b0;
    io_bus.o_LEDData  = 1'b0;
    io_bus.o_SEGData  = 1'b0;
    io_bus.o_LEDLatch = 1'b0;
    io_bus.o_SEGLatch = 1'b0;
    io_bus.o_DIPLatch = 1'b1;
    io_bus.o_LEDAck   = 1'b0;
    io_bus.o_SEGAck   = 1'b0;
    io_bus.o_DIPValid = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_anyReq) w_nextState = S_LOAD;
      end
      S_LOAD: begin
        w_nextState = (r_grant == CH_DIP) ? S_PRELATCH : S_SHIFT;
      end
      S_PRELATCH: begin
        io_bus.o_DIPLatch = 1'b0;
        if (w_phaseLast) w_nextState = S_SHIFT;
      end
      S_SHIFT: begin
        io_bus.o_PSCLK   = (r_phaseCnt >= C_HALF);
        io_bus.o_LEDData = (r_grant == CH_LED) & r_shift[WIDTH-1];
        io_bus.o_SEGData = (r_grant == CH_SEG) & r_shift[WIDTH-1];
        if (w_phaseLast && w_bitLast) w_nextState = (r_grant == CH_DIP) ? S_DONE : S_LATCH;
      end
      S_LATCH: begin
        io_bus.o_LEDLatch = (r_grant == CH_LED);
        io_bus.o_SEGLatch = (r_grant == CH_SEG);
        if (w_phaseLast) w_nextState = S_DONE;
      end
      S_DONE: begin
        io_bus.o_LEDAck   = (r_grant == CH_LED);
        io_bus.o_SEGAck   = (r_grant == CH_SEG);
        io_bus.o_DIPValid = (r_grant == CH_DIP);
        w_nextState       = S_IDLE;
      end
      default: w_nextState = S_IDLE;
    endcase
  end

  assign io_bus.o_DIP16 = r_dip16;
  assign io_bus.o_Busy  = (r_state != S_IDLE);

endmodule
